// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: widths, opcode fields, fetch states.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Opcode class lives in the upper nibble of the opcode byte
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;

  localparam logic [3:0] OP_LDM = 4'hC;

  typedef enum logic [1:0] {
    VECTOR = 2'd0,
    FETCH  = 2'd1,
    IMM    = 2'd2
  } fetch_state_t;

  function automatic logic [3:0] op_class(input logic [DATA_W-1:0] op);
    return op[OPC_HI:OPC_LO];
  endfunction

  // Only LDM carries an immediate byte; every other opcode is one byte long
  function automatic logic is_two_byte(input logic [DATA_W-1:0] op);
    return op_class(op) == OP_LDM;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, assembles 1/2-byte instructions from the
// byte stream and hands them to decode through a one-entry valid/ready register.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 8'h00,
  parameter bit                VECTOR_FETCH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_two_byte,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next
);

  localparam fetch_state_t RESET_STATE = VECTOR_FETCH ? VECTOR : FETCH;

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc_r, pc_next, pc_inc;
  logic              valid_next;

  // Opcode of a two-byte instruction waiting for its immediate
  logic [DATA_W-1:0] held_op_p0;
  logic [ADDR_W-1:0] held_pc_p0;
  logic              capture;

  // Values to load into the output register when load is set
  logic              load;
  logic [DATA_W-1:0] ld_instr, ld_imm;
  logic              ld_two_byte;
  logic [ADDR_W-1:0] ld_pc;

  logic slot_free;

  assign pc        = pc_r;
  assign pc_inc    = pc_r + ADDR_W'(1);
  assign slot_free = !out_valid || out_ready;

  // Next-state, PC and output-register load decisions; redirect wins over all
  always_comb begin
    state_next  = state;
    pc_next     = pc_r;
    valid_next  = out_valid;
    capture     = 1'b0;
    load        = 1'b0;
    ld_instr    = held_op_p0;
    ld_imm      = instr_in;
    ld_two_byte = 1'b1;
    ld_pc       = held_pc_p0;
    if (redirect) begin
      pc_next    = redirect_pc;
      state_next = FETCH;
      valid_next = 1'b0;
    end else begin
      case (state)
        VECTOR: begin
          pc_next    = instr_in;
          state_next = FETCH;
        end
        FETCH: begin
          if (slot_free) begin
            pc_next = pc_inc;
            if (is_two_byte(instr_in)) begin
              capture    = 1'b1;
              state_next = IMM;
              valid_next = 1'b0;
            end else begin
              load        = 1'b1;
              ld_instr    = instr_in;
              ld_imm      = '0;
              ld_two_byte = 1'b0;
              ld_pc       = pc_r;
              valid_next  = 1'b1;
            end
          end
        end
        IMM: begin
          if (slot_free) begin
            load       = 1'b1;
            valid_next = 1'b1;
            pc_next    = pc_inc;
            state_next = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end
  end

  // Control state, PC and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESET_STATE;
      pc_r         <= RESET_PC;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_imm      <= '0;
      out_two_byte <= 1'b0;
      out_pc       <= '0;
      out_pc_next  <= '0;
    end else begin
      state     <= state_next;
      pc_r      <= pc_next;
      out_valid <= valid_next;
      if (load) begin
        out_instr    <= ld_instr;
        out_imm      <= ld_imm;
        out_two_byte <= ld_two_byte;
        out_pc       <= ld_pc;
        out_pc_next  <= pc_inc;
      end
    end
  end

  // Held opcode is qualified by the IMM state, so it needs no reset
  always_ff @(posedge clk) begin
    if (capture) begin
      held_op_p0 <= instr_in;
      held_pc_p0 <= pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: direct reset PC
  logic       rst0, redir0, ready0;
  logic [7:0] rpc0, pc0, instr0;
  logic       v0, tb0;
  logic [7:0] ins0, imm0, opc0, opcn0;
  logic [7:0] mem0 [256];
  assign instr0 = mem0[pc0];

  // Instance 1: indirect reset vector
  logic       rst1;
  logic       redir1 = 1'b0, ready1 = 1'b1;
  logic [7:0] rpc1 = 8'h00;
  logic [7:0] pc1, instr1;
  logic       v1, tb1;
  logic [7:0] ins1, imm1, opc1, opcn1;
  logic [7:0] mem1 [256];
  assign instr1 = mem1[pc1];

  fetch_unit #(.RESET_PC(8'h00), .VECTOR_FETCH(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .pc(pc0), .instr_in(instr0),
    .redirect(redir0), .redirect_pc(rpc0), .out_ready(ready0),
    .out_valid(v0), .out_instr(ins0), .out_imm(imm0),
    .out_two_byte(tb0), .out_pc(opc0), .out_pc_next(opcn0)
  );

  fetch_unit #(.RESET_PC(8'h00), .VECTOR_FETCH(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .pc(pc1), .instr_in(instr1),
    .redirect(redir1), .redirect_pc(rpc1), .out_ready(ready1),
    .out_valid(v1), .out_instr(ins1), .out_imm(imm1),
    .out_two_byte(tb1), .out_pc(opc1), .out_pc_next(opcn1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rdy;
    logic       rd;
    logic [7:0] rpc;
    logic       v;
    logic [7:0] ins;
    logic [7:0] imm;
    logic       tb;
    logic [7:0] opc;
    logic [7:0] opcn;
    logic [7:0] pc;
  } vec_t;

  vec_t tbl [16];

  // Reference decode of the instruction starting at addr in mem0
  logic [7:0] m_op, m_imm, m_next;
  logic       m_tb;
  task automatic decode(input logic [7:0] addr);
    m_op   = mem0[addr];
    m_tb   = (m_op >> 4) == 8'h0C;
    m_imm  = m_tb ? mem0[8'(addr + 8'd1)] : 8'h00;
    m_next = m_tb ? 8'(addr + 8'd2) : 8'(addr + 8'd1);
  endtask

  initial begin
    logic [7:0] exp_addr;
    int         idle;
    logic [7:0] b;

    rst0 = 1'b1; rst1 = 1'b1;
    ready0 = 1'b0; redir0 = 1'b0; rpc0 = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[8'h00] = 8'h10; mem0[8'h01] = 8'h20; mem0[8'h02] = 8'hC0;
    mem0[8'h03] = 8'h05; mem0[8'h04] = 8'h11; mem0[8'h05] = 8'h10;
    mem0[8'h06] = 8'hC1; mem0[8'h07] = 8'h33; mem0[8'h40] = 8'h12;
    mem0[8'h41] = 8'hC2; mem0[8'h42] = 8'h9A; mem0[8'h50] = 8'h13;
    mem1[8'h00] = 8'h80; mem1[8'h80] = 8'h12; mem1[8'h81] = 8'h44;

    //            rdy   rd    rpc    v     ins    imm    tb    opc    opcn   pc
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00, 1'b0, 8'h00, 8'h01, 8'h01};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h20, 8'h00, 1'b0, 8'h01, 8'h02, 8'h02};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h20, 8'h00, 1'b0, 8'h01, 8'h02, 8'h03};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hC0, 8'h05, 1'b1, 8'h02, 8'h04, 8'h04};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0, 8'h04, 8'h05, 8'h05};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0, 8'h04, 8'h05, 8'h05};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0, 8'h04, 8'h05, 8'h05};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h11, 8'h00, 1'b0, 8'h04, 8'h05, 8'h05};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00, 1'b0, 8'h05, 8'h06, 8'h06};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0, 8'h05, 8'h06, 8'h07};
    tbl[10] = '{1'b1, 1'b1, 8'h40, 1'b0, 8'h10, 8'h00, 1'b0, 8'h05, 8'h06, 8'h40};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 8'h00, 1'b0, 8'h40, 8'h41, 8'h41};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h12, 8'h00, 1'b0, 8'h40, 8'h41, 8'h42};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hC2, 8'h9A, 1'b1, 8'h41, 8'h43, 8'h43};
    tbl[14] = '{1'b0, 1'b1, 8'h50, 1'b0, 8'hC2, 8'h9A, 1'b1, 8'h41, 8'h43, 8'h50};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h00, 1'b0, 8'h50, 8'h51, 8'h51};

    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_pc", pc0, 8'h00);
    chk("rst_valid", v0, 1'b0);
    chk("rst_instr", ins0, 8'h00);
    chk("rst_imm", imm0, 8'h00);
    chk("rst_two_byte", tb0, 1'b0);
    chk("rst_out_pc", opc0, 8'h00);
    chk("rst_out_pc_next", opcn0, 8'h00);
    chk("rst_vec_pc", pc1, 8'h00);
    chk("rst_vec_valid", v1, 1'b0);

    rst0 = 1'b0;
    for (int r = 0; r < 16; r++) begin
      ready0 = tbl[r].rdy;
      redir0 = tbl[r].rd;
      rpc0   = tbl[r].rpc;
      step();
      chk($sformatf("row%0d_valid", r), v0, tbl[r].v);
      chk($sformatf("row%0d_instr", r), ins0, tbl[r].ins);
      chk($sformatf("row%0d_imm", r), imm0, tbl[r].imm);
      chk($sformatf("row%0d_two_byte", r), tb0, tbl[r].tb);
      chk($sformatf("row%0d_out_pc", r), opc0, tbl[r].opc);
      chk($sformatf("row%0d_out_pc_next", r), opcn0, tbl[r].opcn);
      chk($sformatf("row%0d_pc", r), pc0, tbl[r].pc);
    end

    // Two-byte instruction straddling the 8'hFF -> 8'h00 wrap
    mem0[8'hFF] = 8'hC3;
    mem0[8'h00] = 8'h7A;
    ready0 = 1'b1; redir0 = 1'b1; rpc0 = 8'hFF;
    step();
    redir0 = 1'b0;
    chk("wrap_redir_pc", pc0, 8'hFF);
    chk("wrap_redir_valid", v0, 1'b0);
    step();
    chk("wrap_op_pc", pc0, 8'h00);
    chk("wrap_op_valid", v0, 1'b0);
    step();
    chk("wrap_valid", v0, 1'b1);
    chk("wrap_instr", ins0, 8'hC3);
    chk("wrap_imm", imm0, 8'h7A);
    chk("wrap_two_byte", tb0, 1'b1);
    chk("wrap_out_pc", opc0, 8'hFF);
    chk("wrap_out_pc_next", opcn0, 8'h01);
    chk("wrap_pc", pc0, 8'h01);

    // Asynchronous reset in mid-operation acts without a clock edge
    #2 rst0 = 1'b1;
    #1;
    chk("async_rst_pc", pc0, 8'h00);
    chk("async_rst_valid", v0, 1'b0);
    chk("async_rst_out_pc", opc0, 8'h00);

    // Indirect reset vector on instance 1
    @(negedge clk);
    rst1 = 1'b0;
    step();
    chk("vec_pc_loaded", pc1, 8'h80);
    chk("vec_no_output", v1, 1'b0);
    step();
    chk("vec_valid", v1, 1'b1);
    chk("vec_instr", ins1, 8'h12);
    chk("vec_out_pc", opc1, 8'h80);
    chk("vec_out_pc_next", opcn1, 8'h81);
    chk("vec_pc", pc1, 8'h81);

    // Randomized traffic against the instruction-stream model
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 2) == 0) b[7:4] = 4'hC;
      mem0[i] = b;
    end
    redir0 = 1'b0;
    ready0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    exp_addr = 8'h00;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      if (v0) begin
        decode(exp_addr);
        chk("rand_instr", {ins0, imm0, 7'd0, tb0, opc0, opcn0},
            {m_op, m_imm, 7'd0, m_tb, exp_addr, m_next});
        idle = 0;
      end else begin
        idle++;
        chk("rand_idle_bound", 64'(idle > 2), 64'd0);
      end
      ready0 = ($urandom_range(0, 3) != 0);
      redir0 = ($urandom_range(0, 15) == 0);
      rpc0   = 8'($urandom);
      if (v0 && ready0) begin
        decode(exp_addr);
        exp_addr = m_next;
      end
      if (redir0) begin
        exp_addr = rpc0;
        idle = 0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
